vx_barrier_table: RTL and testbench
===================================

VX_BARRIER_TABLE -- requirements
Module: VX_barrier_table

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4: warps tracked, power of two, 2..32.
REQ-002 SHALL have parameter NUM_BARRIERS, default 4: independent barrier slots, power of two, 1..16.
REQ-003 SHALL have parameter CNT_W, default clog2(NUM_WARPS) (min 1): arrival counter and size_m1 width.
REQ-004 SHALL have ports: clk  in  1  single clock, all state rises on posedge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-006 SHALL have ports: req_valid in 1; req_ready out 1; req_wid in clog2(NUM_WARPS); req_id in clog2(NUM_BARRIERS) (min 1).
REQ-007 SHALL have ports: req_size_m1 in CNT_W (participants minus one); req_is_noop in 1; req_is_global in 1.
REQ-008 SHALL have ports: stall_mask out NUM_WARPS (warps waiting); rel_valid out 1; rel_mask out NUM_WARPS.
REQ-009 SHALL have ports: gbar_req_valid out 1; gbar_req_ready in 1; gbar_req_id out clog2(NUM_BARRIERS); gbar_rsp_valid in 1; gbar_rsp_id in clog2(NUM_BARRIERS).

Function
REQ-010 SHALL hold, per slot, state {FREE, COLLECT, GSEND, GWAIT}, arrival count (CNT_W), latched size_m1, and a NUM_WARPS arrival mask.
REQ-011 SHALL accept an arrival when req_valid && req_ready; req_ready SHALL be low iff slot req_id is in GSEND or GWAIT.
REQ-012 SHALL, on arrival to a FREE slot, latch req_size_m1 and go to COLLECT; later size_m1 values for that slot are ignored until it returns to FREE.
REQ-013 SHALL set mask bit req_wid and add 1 to the count per accepted arrival; a repeat arrival from a warp whose bit is already set SHALL change nothing.
REQ-014 SHALL set stall_mask[req_wid] at the cycle after acceptance unless req_is_noop; noop warps SHALL count and appear in the arrival mask but SHALL never be stalled.
REQ-015 SHALL detect completion when the pre-increment count equals size_m1 on an accepted new arrival; size_m1=0 therefore completes on the first arrival.
REQ-016 SHALL, on local completion at cycle T, assert rel_valid for exactly one cycle at T+1 with rel_mask = slot mask including the final warp, clear those stall bits at T+1, and return the slot to FREE at T+1.
REQ-017 SHALL, when two releases coincide (local completion and gbar_rsp), OR both masks into one rel_valid pulse.
REQ-018 SHALL keep rel_mask zero when rel_valid is low.
REQ-019 SHALL accept a new arrival to the slot released at T+1 in cycle T+1 and treat it as a fresh FREE-slot arrival.
REQ-020 SHALL use a count width such that count never wraps: size_m1 <= NUM_WARPS-1 by construction.

Reset
REQ-021 SHALL, on reset high at a clock edge, force every slot to FREE, zero every count and mask, and drive stall_mask=0, rel_valid=0, rel_mask=0, gbar_req_valid=0.
REQ-022 SHALL hold req_ready=1 during and after reset; arrivals presented while reset is high SHALL be discarded, and in-flight global barriers SHALL be abandoned with no release.

Configuration
REQ-023 SHALL compile global-barrier support only when macro VX_BARRIER_GBAR_EN is defined.
REQ-024 SHALL, with VX_BARRIER_GBAR_EN, send a slot completing with any accepted req_is_global arrival to GSEND instead of releasing; in GSEND, gbar_req_valid=1 with gbar_req_id=slot until gbar_req_ready, then go to GWAIT.
REQ-025 SHALL arbitrate multiple GSEND slots by lowest index; on gbar_rsp_valid for a GWAIT slot, release its mask at the next cycle per REQ-016; a response for a non-GWAIT slot SHALL be ignored.
REQ-026 SHALL, without VX_BARRIER_GBAR_EN, treat req_is_global as local, tie gbar_req_valid=0 and gbar_req_id=0, and ignore gbar_rsp_*.

Verification
REQ-027 SHALL cover: wid 0,1,2 arrive id 1 size_m1=2 on consecutive cycles -> stall_mask 0x1,0x3 then rel_valid one cycle with rel_mask=0x7, stall_mask=0.
REQ-028 SHALL cover: size_m1=0 single arrival wid 3 -> rel_valid next cycle, rel_mask=0x8, no stall_mask bit ever seen.
REQ-029 SHALL cover: wid 0 arrives twice then wid 1, size_m1=1 -> release at wid 1 arrival with rel_mask=0x3, duplicate not counted.
REQ-030 SHALL cover: noop arrival wid 2 plus normal wid 0, size_m1=1 -> stall_mask only bit 0, rel_mask=0x5.
REQ-031 SHALL cover (GBAR_EN): global barrier id 2 completes, gbar_req_ready held low 3 cycles -> gbar_req_valid held, req_ready=0 for id 2; rsp -> rel next cycle.
REQ-032 SHALL cover: reset asserted while slot 0 in COLLECT with stall_mask=0x3 -> all outputs zero next cycle, no rel_valid.

Source files
------------

// File: rtl/vx_barrier_table.sv
// Warp barrier table: per-slot arrival collection, local release and optional global handoff.
// Global-barrier support is compiled in only when VX_BARRIER_GBAR_EN is defined.
module vx_barrier_table #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_BARRIERS = 4,
  parameter int unsigned CNT_W        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   req_valid,
  output logic                                                   req_ready,
  input  logic [$clog2(NUM_WARPS)-1:0]                           req_wid,
  input  logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] req_id,
  input  logic [CNT_W-1:0]                                       req_size_m1,
  input  logic                                                   req_is_noop,
  input  logic                                                   req_is_global,
  output logic [NUM_WARPS-1:0]                                   stall_mask,
  output logic                                                   rel_valid,
  output logic [NUM_WARPS-1:0]                                   rel_mask,
  output logic                                                   gbar_req_valid,
  input  logic                                                   gbar_req_ready,
  output logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] gbar_req_id,
  input  logic                                                   gbar_rsp_valid,
  input  logic [((NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1)-1:0] gbar_rsp_id
);

  localparam int unsigned IdW = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef enum logic [1:0] {StFree, StCollect, StGSend, StGWait} slot_st_e;

  slot_st_e             state_q [NUM_BARRIERS];
  slot_st_e             state_d [NUM_BARRIERS];
  logic [CNT_W-1:0]     cnt_q   [NUM_BARRIERS];
  logic [CNT_W-1:0]     cnt_d   [NUM_BARRIERS];
  logic [CNT_W-1:0]     size_q  [NUM_BARRIERS];
  logic [CNT_W-1:0]     size_d  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d  [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] stall_q, stall_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic                 rel_valid_q;
  logic [NUM_WARPS-1:0] set_stall;

  logic [NUM_WARPS-1:0] wid_oh;
  logic [NUM_WARPS-1:0] new_mask;
  logic [CNT_W-1:0]     eff_size;
  logic                 eff_glob;
  logic                 accept;

  assign wid_oh = NUM_WARPS'(1) << req_wid;
  assign accept = req_valid && req_ready;

`ifdef VX_BARRIER_GBAR_EN
  logic [NUM_BARRIERS-1:0] glob_q, glob_d;
  logic                    gsel_valid;
  logic [IdW-1:0]          gsel;

  // Lowest-index GSEND slot wins the global request port.
  always_comb begin
    gsel_valid = 1'b0;
    gsel       = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (state_q[i] == StGSend) begin
        gsel_valid = 1'b1;
        gsel       = IdW'(i);
      end
    end
  end

  assign gbar_req_valid = gsel_valid;
  assign gbar_req_id    = gsel;
  assign req_ready      = reset ||
                          !((state_q[req_id] == StGSend) || (state_q[req_id] == StGWait));
`else
  logic unused_gbar;
  assign unused_gbar    = ^{gbar_req_ready, gbar_rsp_valid, gbar_rsp_id, req_is_global};
  assign gbar_req_valid = 1'b0;
  assign gbar_req_id    = '0;
  assign req_ready      = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    mask_d     = mask_q;
    set_stall  = '0;
    rel_mask_d = '0;
    eff_size   = '0;
    eff_glob   = 1'b0;
    new_mask   = '0;
`ifdef VX_BARRIER_GBAR_EN
    glob_d = glob_q;
    if (gbar_req_valid && gbar_req_ready) begin
      state_d[gsel] = StGWait;
    end
    if (gbar_rsp_valid && (state_q[gbar_rsp_id] == StGWait)) begin
      rel_mask_d             = rel_mask_d | mask_q[gbar_rsp_id];
      state_d[gbar_rsp_id]   = StFree;
      cnt_d[gbar_rsp_id]     = '0;
      mask_d[gbar_rsp_id]    = '0;
      glob_d[gbar_rsp_id]    = 1'b0;
    end
`endif
    // A repeat arrival from an already-recorded warp leaves the slot untouched.
    if (accept && !mask_q[req_id][req_wid]) begin
      eff_size = (state_q[req_id] == StFree) ? req_size_m1 : size_q[req_id];
      new_mask = mask_q[req_id] | wid_oh;
`ifdef VX_BARRIER_GBAR_EN
      eff_glob = glob_q[req_id] || req_is_global;
      glob_d[req_id] = eff_glob;
`endif
      size_d[req_id] = eff_size;
      if ((cnt_q[req_id] == eff_size) && !eff_glob) begin
        rel_mask_d     = rel_mask_d | new_mask;
        state_d[req_id] = StFree;
        cnt_d[req_id]   = '0;
        mask_d[req_id]  = '0;
`ifdef VX_BARRIER_GBAR_EN
        glob_d[req_id]  = 1'b0;
`endif
      end else begin
        state_d[req_id] = (cnt_q[req_id] == eff_size) ? StGSend : StCollect;
        cnt_d[req_id]   = (cnt_q[req_id] == eff_size) ? cnt_q[req_id]
                                                      : cnt_q[req_id] + CNT_W'(1);
        mask_d[req_id]  = new_mask;
        if (!req_is_noop) begin
          set_stall = wid_oh;
        end
      end
    end
    stall_d = (stall_q | set_stall) & ~rel_mask_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        state_q[i] <= StFree;
        cnt_q[i]   <= '0;
        size_q[i]  <= '0;
        mask_q[i]  <= '0;
      end
`ifdef VX_BARRIER_GBAR_EN
      glob_q      <= '0;
`endif
      stall_q     <= '0;
      rel_mask_q  <= '0;
      rel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      mask_q      <= mask_d;
`ifdef VX_BARRIER_GBAR_EN
      glob_q      <= glob_d;
`endif
      stall_q     <= stall_d;
      rel_mask_q  <= rel_mask_d;
      rel_valid_q <= |rel_mask_d;
    end
  end

  assign stall_mask = stall_q;
  assign rel_valid  = rel_valid_q;
  assign rel_mask   = rel_mask_q;

endmodule

// File: tb/tb_vx_barrier_table.sv
// Scoreboard bench for vx_barrier_table: stimulus queues expected releases, a monitor checks them.
module tb_vx_barrier_table;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_wid = '0;
  logic [1:0] req_id = '0;
  logic [1:0] req_size_m1 = '0;
  logic       req_is_noop = 1'b0;
  logic       req_is_global = 1'b0;
  logic [3:0] stall_mask;
  logic       rel_valid;
  logic [3:0] rel_mask;
  logic       gbar_req_valid;
  logic       gbar_req_ready = 1'b0;
  logic [1:0] gbar_req_id;
  logic       gbar_rsp_valid = 1'b0;
  logic [1:0] gbar_rsp_id = '0;

  vx_barrier_table dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_wid       (req_wid),
    .req_id        (req_id),
    .req_size_m1   (req_size_m1),
    .req_is_noop   (req_is_noop),
    .req_is_global (req_is_global),
    .stall_mask    (stall_mask),
    .rel_valid     (rel_valid),
    .rel_mask      (rel_mask),
    .gbar_req_valid(gbar_req_valid),
    .gbar_req_ready(gbar_req_ready),
    .gbar_req_id   (gbar_req_id),
    .gbar_rsp_valid(gbar_rsp_valid),
    .gbar_rsp_id   (gbar_rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } rel_exp_t;

  rel_exp_t exp_q[$];
  int edge_cnt = 0;
  int vectors = 0;
  int errors = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Release monitor: every rel_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rel_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_rel: got mask %0h at edge %0d expected no release",
                 rel_mask, edge_cnt);
      end else begin
        rel_exp_t e;
        e = exp_q.pop_front();
        chk("rel_edge", edge_cnt, e.cyc);
        chk("rel_mask", {28'd0, rel_mask}, {28'd0, e.mask});
      end
    end else if (rel_valid === 1'b0 && rel_mask !== 4'h0) begin
      vectors++;
      errors++;
      $display("FAIL rel_mask_idle: got %0h expected 0", rel_mask);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rel(input logic [3:0] m);
    rel_exp_t e;
    e.cyc  = edge_cnt + 1;
    e.mask = m;
    exp_q.push_back(e);
  endtask

  task automatic arrive(input int wid, input int id, input int sz, input bit noop,
                        input bit glob, input logic [3:0] exp_rel);
    req_valid     = 1'b1;
    req_wid       = 2'(wid);
    req_id        = 2'(id);
    req_size_m1   = 2'(sz);
    req_is_noop   = noop;
    req_is_global = glob;
    if (exp_rel != 4'h0) push_rel(exp_rel);
    tick();
    req_valid     = 1'b0;
    req_is_noop   = 1'b0;
    req_is_global = 1'b0;
  endtask

  initial begin
    // Reset state
    chk("ready_in_reset", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    chk("rst_stall", {28'd0, stall_mask}, 32'h0);
    chk("rst_rel_valid", {31'd0, rel_valid}, 32'd0);
    chk("rst_gbar_valid", {31'd0, gbar_req_valid}, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

    // Three warps on slot 1, size_m1=2
    arrive(0, 1, 2, 0, 0, 4'h0);
    chk("b1_stall_a", {28'd0, stall_mask}, 32'h1);
    arrive(1, 1, 2, 0, 0, 4'h0);
    chk("b1_stall_b", {28'd0, stall_mask}, 32'h3);
    arrive(2, 1, 2, 0, 0, 4'h7);
    chk("b1_stall_rel", {28'd0, stall_mask}, 32'h0);
    tick();

    // size_m1=0 completes on the first arrival without stalling
    arrive(3, 0, 0, 0, 0, 4'h8);
    chk("b0_stall", {28'd0, stall_mask}, 32'h0);
    tick();

    // Duplicate arrival ignored; later size_m1 ignored
    arrive(0, 2, 1, 0, 0, 4'h0);
    chk("dup_stall_a", {28'd0, stall_mask}, 32'h1);
    arrive(0, 2, 0, 0, 0, 4'h0);
    chk("dup_stall_b", {28'd0, stall_mask}, 32'h1);
    arrive(1, 2, 3, 0, 0, 4'h3);
    chk("dup_stall_rel", {28'd0, stall_mask}, 32'h0);
    tick();

    // Noop warp counts but never stalls
    arrive(0, 3, 1, 0, 0, 4'h0);
    chk("noop_stall_a", {28'd0, stall_mask}, 32'h1);
    arrive(2, 3, 1, 1, 0, 4'h5);
    chk("noop_stall_rel", {28'd0, stall_mask}, 32'h0);
    tick();

    // Slot reused in the cycle right after its release
    arrive(0, 1, 0, 0, 0, 4'h1);
    arrive(1, 1, 1, 0, 0, 4'h0);
    chk("reuse_stall", {28'd0, stall_mask}, 32'h2);
    arrive(3, 1, 1, 0, 0, 4'ha);
    chk("reuse_stall_rel", {28'd0, stall_mask}, 32'h0);
    tick();

`ifdef VX_BARRIER_GBAR_EN
    // Global barrier on slot 2 with a stalled request port
    arrive(0, 2, 1, 0, 1, 4'h0);
    chk("g_stall_a", {28'd0, stall_mask}, 32'h1);
    arrive(1, 2, 1, 0, 0, 4'h0);
    chk("g_stall_b", {28'd0, stall_mask}, 32'h3);
    req_id = 2'd2;
    for (int i = 0; i < 3; i++) begin
      chk("g_req_valid_held", {31'd0, gbar_req_valid}, 32'd1);
      chk("g_req_id", {30'd0, gbar_req_id}, 32'd2);
      chk("g_ready_low", {31'd0, req_ready}, 32'd0);
      tick();
    end
    gbar_req_ready = 1'b1;
    tick();
    gbar_req_ready = 1'b0;
    chk("g_req_valid_done", {31'd0, gbar_req_valid}, 32'd0);
    chk("g_ready_wait", {31'd0, req_ready}, 32'd0);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'd3;
    tick();
    gbar_rsp_id    = 2'd2;
    push_rel(4'h7);
    arrive(2, 0, 0, 0, 0, 4'h0);
    gbar_rsp_valid = 1'b0;
    chk("g_stall_rel", {28'd0, stall_mask}, 32'h0);
    req_id = 2'd2;
    #1;
    chk("g_ready_back", {31'd0, req_ready}, 32'd1);
    tick();
`else
    // Global flag behaves as a local barrier; global responses are ignored
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = 2'd2;
    arrive(2, 2, 0, 0, 1, 4'h4);
    gbar_rsp_valid = 1'b0;
    chk("nog_req_valid", {31'd0, gbar_req_valid}, 32'd0);
    chk("nog_stall", {28'd0, stall_mask}, 32'h0);
    tick();
`endif

    // Reset during collection clears everything with no release
    arrive(0, 0, 3, 0, 0, 4'h0);
    arrive(1, 0, 3, 0, 0, 4'h0);
    chk("pre_rst_stall", {28'd0, stall_mask}, 32'h3);
    reset = 1'b1;
    arrive(2, 0, 3, 0, 0, 4'h0);
    chk("mid_rst_stall", {28'd0, stall_mask}, 32'h0);
    chk("mid_rst_rel", {31'd0, rel_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    reset = 1'b0;
    arrive(3, 0, 0, 0, 0, 4'h8);
    chk("post_rst_stall", {28'd0, stall_mask}, 32'h0);
    tick();
    tick();

    chk("pending_rel", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
